// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the FIFO read-side controller: skid depth, occupancy
// encoding, reset level and the read-issue credit check.
package sync_fifo_pkg;

  localparam int SKID_DEPTH = 2;
  localparam int OCC_W = 2;
  localparam logic RST_LEVEL = 1'b0;

  typedef enum logic [OCC_W-1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // A read may be issued only if, after this cycle's pop, the held word(s)
  // plus the in-flight word still leave room for the new word in the skid.
  function automatic logic can_issue(input logic [OCC_W-1:0] held,
                                     input logic inflight,
                                     input logic pop);
    logic [2:0] used_s;
    logic [2:0] limit_s;
    used_s  = {1'b0, held} + {2'b00, inflight};
    limit_s = 3'(SKID_DEPTH) + {2'b00, pop};
    return (used_s < limit_s);
  endfunction

endpackage

// File: rtl/sync_fifo_skid.sv
// Two-entry in-order skid buffer; slot0 is always the head and drives the
// stream data register directly.
module sync_fifo_skid
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  valid,
  output logic [OCC_W-1:0]      held
);

  occ_e                  state_r, state_s;
  logic [DATA_WIDTH-1:0] slot0_r, slot0_s;
  logic [DATA_WIDTH-1:0] slot1_r, slot1_s;
  logic                  valid_r;

  // Occupancy state, slot storage and the registered valid flag.
  always_ff @(posedge clk or negedge reset) begin
    if (reset == RST_LEVEL) begin
      state_r <= OCC_EMPTY;
      slot0_r <= {DATA_WIDTH{1'b0}};
      slot1_r <= {DATA_WIDTH{1'b0}};
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      slot0_r <= slot0_s;
      slot1_r <= slot1_s;
      valid_r <= (state_s != OCC_EMPTY);
    end
  end

  // Next occupancy and slot contents; flush empties the buffer and drops any arrival.
  always_comb begin
    state_s = state_r;
    slot0_s = slot0_r;
    slot1_s = slot1_r;
    if (flush) begin
      state_s = OCC_EMPTY;
    end else begin
      case (state_r)
        OCC_EMPTY: begin
          if (push) begin
            slot0_s = push_data;
            state_s = OCC_ONE;
          end else begin
            state_s = OCC_EMPTY;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            slot0_s = push_data;
            state_s = OCC_ONE;
          end else if (push) begin
            slot1_s = push_data;
            state_s = OCC_TWO;
          end else if (pop) begin
            state_s = OCC_EMPTY;
          end else begin
            state_s = OCC_ONE;
          end
        end
        OCC_TWO: begin
          // Full: arrivals only ever coincide with a pop here.
          if (pop) begin
            slot0_s = slot1_r;
            if (push) begin
              slot1_s = push_data;
              state_s = OCC_TWO;
            end else begin
              slot1_s = slot1_r;
              state_s = OCC_ONE;
            end
          end else begin
            state_s = OCC_TWO;
          end
        end
        default: begin
          state_s = OCC_EMPTY;
        end
      endcase
    end
  end

  assign head_data = slot0_r;
  assign valid     = valid_r;
  assign held      = state_r;

endmodule

// File: rtl/sync_fifo_reader.sv
// Read-side controller for synchronous_fifo: issues reads against skid credit,
// tracks the in-flight word and counts words accepted downstream.
module sync_fifo_reader
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  words_out
);

  logic                 inflight_r;
  logic                 pop_s;
  logic                 rd_en_s;
  logic [OCC_W-1:0]     held_s;
  logic [CNT_WIDTH-1:0] words_out_r;

  assign pop_s = m_valid & m_ready;

  // Reset term keeps the strobe low for the whole asynchronous reset window.
  assign rd_en_s = (reset != RST_LEVEL) & enable & ~flush & ~fifo_empty &
                   can_issue(held_s, inflight_r, pop_s);
  assign fifo_rd_en = rd_en_s;

  // In-flight flag mirrors the read strobe; a flush cycle never issues, so it clears too.
  always_ff @(posedge clk or negedge reset) begin
    if (reset == RST_LEVEL) begin
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= rd_en_s;
    end
  end

  // Delivered-word counter, wraps naturally; flush does not touch it.
  always_ff @(posedge clk or negedge reset) begin
    if (reset == RST_LEVEL) begin
      words_out_r <= {CNT_WIDTH{1'b0}};
    end else if (pop_s) begin
      words_out_r <= words_out_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      words_out_r <= words_out_r;
    end
  end

  sync_fifo_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .push     (inflight_r),
    .push_data(fifo_rd_data),
    .pop      (pop_s),
    .head_data(m_data),
    .valid    (m_valid),
    .held     (held_s)
  );

  assign words_out = words_out_r;

endmodule

// File: tb/tb_sync_fifo_reader.sv
// Directed bench for sync_fifo_reader with a small 4-deep synchronous FIFO
// model upstream and a log of every word accepted downstream.
module tb_sync_fifo_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        flush = 1'b0;
  logic        m_ready = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        fifo_empty;
  logic [7:0]  fifo_rd_data = 8'h00;
  logic        fifo_rd_en;
  logic        m_valid;
  logic [7:0]  m_data;
  logic [15:0] words_out;

  int errors = 0;
  int checks = 0;
  int rd_pulses = 0;
  int rd_while_empty = 0;
  int p0;
  int b;
  logic [7:0] got[$];
  logic [7:0] words[4] = '{8'h5D, 8'hD4, 8'hF3, 8'h0D};

  always #5 clk = ~clk;

  sync_fifo_reader #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .words_out(words_out)
  );

  // Upstream FIFO model, depth 4, read data valid the cycle after rd_en
  logic [7:0] fmem[4];
  logic [2:0] fcnt = 3'd0;
  logic [1:0] wp = 2'd0;
  logic [1:0] rp = 2'd0;
  wire wr_ok = wr_en && (fcnt < 3'd4);
  wire rd_ok = fifo_rd_en && (fcnt != 3'd0);
  assign fifo_empty = (fcnt == 3'd0);

  always @(posedge clk) begin
    if (wr_ok) begin fmem[wp] <= wr_data; wp <= wp + 2'd1; end
    if (rd_ok) begin fifo_rd_data <= fmem[rp]; rp <= rp + 2'd1; end
    fcnt <= fcnt + {2'b00, wr_ok} - {2'b00, rd_ok};
  end

  always @(posedge clk) begin
    if (reset && m_valid && m_ready) got.push_back(m_data);
  end

  always @(negedge clk) begin
    if (fifo_rd_en) rd_pulses++;
    if (fifo_rd_en && fifo_empty) rd_while_empty++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // exp_w holds n bytes, first-delivered word in the most significant used byte
  task automatic chk_seq(input string tag, input int base, input int n, input logic [31:0] exp_w);
    logic [7:0] v;
    chk({tag, "_count"}, got.size(), base + n);
    for (int i = 0; i < n; i++) begin
      v = (base + i < got.size()) ? got[base + i] : 8'h00;
      chk($sformatf("%s_w%0d", tag, i), {24'h0, v}, {24'h0, exp_w[8*(n-1-i) +: 8]});
    end
  endtask

  task automatic write_words();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1;
      wr_data = words[i];
      step();
    end
    wr_en = 1'b0;
  endtask

  initial begin
    // reset state
    step(); step();
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_words", words_out, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    reset = 1'b1;
    step();

    // 1: full-rate streaming and 2-cycle latency
    enable = 1'b1; m_ready = 1'b1; b = got.size();
    wr_en = 1'b1; wr_data = 8'h5D; step();
    wr_data = 8'hD4; step();
    chk("t1_lat1_valid", m_valid, 0);
    wr_data = 8'hF3; step();
    chk("t1_lat2_valid", m_valid, 1);
    chk("t1_d0", m_data, 8'h5D);
    wr_data = 8'h0D; step();
    chk("t1_d1", m_data, 8'hD4);
    wr_en = 1'b0; step();
    chk("t1_d2", m_data, 8'hF3);
    step();
    chk("t1_d3", m_data, 8'h0D);
    step();
    chk("t1_idle_valid", m_valid, 0);
    chk("t1_words", words_out, 4);
    chk_seq("t1_order", b, 4, 32'h5DD4F30D);

    // 2: backpressure from the start
    m_ready = 1'b0; p0 = rd_pulses; b = got.size();
    write_words();
    step(); step(); step();
    chk("t2_rd_pulses", rd_pulses - p0, 2);
    chk("t2_valid", m_valid, 1);
    chk("t2_data", m_data, 8'h5D);
    step();
    chk("t2_data_stable", m_data, 8'h5D);
    chk("t2_none_taken", got.size(), b);
    m_ready = 1'b1;
    repeat (8) step();
    chk_seq("t2_order", b, 4, 32'h5DD4F30D);
    chk("t2_words", words_out, 8);
    chk("t2_idle_valid", m_valid, 0);

    // 3: toggling ready
    b = got.size();
    for (int i = 0; i < 14; i++) begin
      wr_en = (i < 4);
      wr_data = (i < 4) ? words[i] : 8'h00;
      m_ready = (i % 2 == 0);
      step();
    end
    wr_en = 1'b0; m_ready = 1'b1;
    repeat (4) step();
    chk_seq("t3_order", b, 4, 32'h5DD4F30D);
    chk("t3_words", words_out, 12);
    chk("t3_idle_valid", m_valid, 0);

    // 4: enable dropped after the first read
    enable = 1'b0; m_ready = 1'b1; p0 = rd_pulses; b = got.size();
    write_words();
    chk("t4_no_rd_disabled", rd_pulses - p0, 0);
    chk("t4_rd_en_low", fifo_rd_en, 0);
    enable = 1'b1;
    #1;
    chk("t4_rd_en_high", fifo_rd_en, 1);
    step();
    enable = 1'b0;
    repeat (5) step();
    chk("t4_one_pulse", rd_pulses - p0, 1);
    chk_seq("t4_first", b, 1, 32'h0000005D);
    chk("t4_drained_valid", m_valid, 0);
    enable = 1'b1;
    repeat (8) step();
    chk_seq("t4_order", b, 4, 32'h5DD4F30D);
    chk("t4_words", words_out, 16);

    // 5: flush with 5D held and D4 in flight
    enable = 1'b0; m_ready = 1'b0; b = got.size();
    write_words();
    enable = 1'b1;
    step();
    step();
    flush = 1'b1;
    #1;
    chk("t5_no_rd_in_flush", fifo_rd_en, 0);
    step();
    flush = 1'b0;
    chk("t5_valid_cleared", m_valid, 0);
    chk("t5_words_kept", words_out, 16);
    m_ready = 1'b1;
    repeat (6) step();
    chk_seq("t5_order", b, 2, 32'h0000F30D);
    chk("t5_words", words_out, 18);
    chk("t5_idle_valid", m_valid, 0);

    // 6: asynchronous reset mid-stream
    enable = 1'b1; m_ready = 1'b1; b = got.size();
    write_words();
    #1 reset = 1'b0;
    #1;
    chk("t6_rst_valid", m_valid, 0);
    chk("t6_rst_data", m_data, 0);
    chk("t6_rst_words", words_out, 0);
    chk("t6_rst_rd_en", fifo_rd_en, 0);
    reset = 1'b1;
    step();
    step();
    chk("t6_resume_valid", m_valid, 1);
    chk("t6_resume_data", m_data, 8'h0D);
    step();
    chk("t6_words", words_out, 1);
    chk("t6_idle_valid", m_valid, 0);
    chk_seq("t6_order", b, 2, 32'h00005D0D);

    chk("rd_while_empty", rd_while_empty, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
